// File: rtl/fwd_pkg.sv
// Shared types and sizing helpers for the forwarding/hazard unit.
package fwd_pkg;

  localparam int unsigned NFS_MAX    = 8;
  localparam int unsigned LD_LAT_MAX = NFS_MAX - 1;

  typedef enum logic {IDLE, LDWAIT} fwd_state_e;

  // Width of the bubble counter and stage index; never narrower than one bit.
  function automatic int unsigned clog2(input int unsigned nfs);
    int unsigned w;
    w = 0;
    while ((1 << w) < nfs) w++;
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// Pipeline-side bus of the forwarding/hazard unit; stat outputs exist only with FWD_STAT_EN.
interface fwd_hazard_unit_if #(
  parameter int NRP    = 2,
  parameter int NFS    = 3,
  parameter int RADR_W = 5
);
  logic [NRP*RADR_W-1:0] rs_id;
  logic [NRP-1:0]        rs_valid;
  logic [NFS*RADR_W-1:0] rd_adr_st;
  logic [NFS-1:0]        wbk_st;
  logic [NFS-1:0]        ld_st;
  logic [NFS-1:0]        stall_st;
  logic                  stall_fin2;
  logic                  rst_pipe;
  logic [NRP*NFS-1:0]    fwd_sel_ex;
  logic [NRP-1:0]        nohit_ex;
  logic                  stall_ld;
  logic                  stall_ld_ex;
  logic                  ld_busy;
`ifdef FWD_STAT_EN
  logic [31:0]           stat_ldstall_cnt;
  logic [31:0]           stat_fwd0_cnt;

  modport master (
    output rs_id, rs_valid, rd_adr_st, wbk_st, ld_st, stall_st, stall_fin2, rst_pipe,
    input  fwd_sel_ex, nohit_ex, stall_ld, stall_ld_ex, ld_busy, stat_ldstall_cnt, stat_fwd0_cnt
  );
  modport slave (
    input  rs_id, rs_valid, rd_adr_st, wbk_st, ld_st, stall_st, stall_fin2, rst_pipe,
    output fwd_sel_ex, nohit_ex, stall_ld, stall_ld_ex, ld_busy, stat_ldstall_cnt, stat_fwd0_cnt
  );
`else
  modport master (
    output rs_id, rs_valid, rd_adr_st, wbk_st, ld_st, stall_st, stall_fin2, rst_pipe,
    input  fwd_sel_ex, nohit_ex, stall_ld, stall_ld_ex, ld_busy
  );
  modport slave (
    input  rs_id, rs_valid, rd_adr_st, wbk_st, ld_st, stall_st, stall_fin2, rst_pipe,
    output fwd_sel_ex, nohit_ex, stall_ld, stall_ld_ex, ld_busy
  );
`endif
endinterface

// File: rtl/fwd_port_cmp.sv
// One read port: stage compares, nearest-stage bypass select and load-hazard detection.
module fwd_port_cmp
  import fwd_pkg::*;
#(
  parameter int NFS    = 3,
  parameter int RADR_W = 5,
  parameter int LD_LAT = 1,
  parameter int CW     = 2
) (
  input  logic [RADR_W-1:0]     rs,
  input  logic                  rs_valid,
  input  logic [NFS*RADR_W-1:0] rd_adr_st,
  input  logic [NFS-1:0]        wbk_st,
  input  logic [NFS-1:0]        ld_st,
  input  logic [NFS-1:0]        stall_st,
  input  logic                  mask_near,
  output logic [NFS-1:0]        sel,
  output logic                  nohit,
  output logic                  haz,
  output logic [CW-1:0]         kmin
);

  logic [RADR_W-1:0] rd;
  logic              hit;
  logic              near;
  logic              found;

  // Ascending scan: first forwardable stage wins, first hazard stage sets kmin.
  always_comb begin
    sel   = '0;
    haz   = 1'b0;
    kmin  = '0;
    found = 1'b0;
    rd    = '0;
    hit   = 1'b0;
    near  = 1'b0;
    for (int unsigned k = 0; k < NFS; k++) begin
      rd   = rd_adr_st[k*RADR_W +: RADR_W];
      hit  = (rd != '0) && (rs == rd) && rs_valid && wbk_st[k] && !stall_st[k];
      near = (k < LD_LAT);
      if (hit && ld_st[k] && near) begin
        if (!haz) kmin = CW'(k);
        haz = 1'b1;
      end else if (hit && !found && !(mask_near && near)) begin
        sel[k] = 1'b1;
        found  = 1'b1;
      end
    end
    nohit = ~found;
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding select registers and load-use stall FSM; optional stats under FWD_STAT_EN.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int NRP    = 2,
  parameter int NFS    = 3,
  parameter int RADR_W = 5,
  parameter int LD_LAT = 1
) (
  input logic               clk,
  input logic               rst_n,
  fwd_hazard_unit_if.slave  bus
);

  localparam int CW = clog2(NFS);

  if (LD_LAT < 1 || LD_LAT > NFS - 1 || LD_LAT > LD_LAT_MAX) begin : g_bad_ld_lat
    $error("fwd_hazard_unit: LD_LAT must be within 1..NFS-1");
  end

  fwd_state_e         state;
  logic [CW-1:0]      cnt;
  logic [NRP*NFS-1:0] sel_nxt;
  logic [NRP-1:0]     nohit_nxt;
  logic [NRP-1:0]     haz;
  logic [CW-1:0]      kmin_p [NRP];
  logic [CW-1:0]      kmin_all;
  logic [CW-1:0]      need;
  logic [CW-1:0]      cnt_dec;
  logic               any_haz;

  for (genvar p = 0; p < NRP; p++) begin : g_port
    fwd_port_cmp #(.NFS(NFS), .RADR_W(RADR_W), .LD_LAT(LD_LAT), .CW(CW)) u_cmp (
      .rs        (bus.rs_id[p*RADR_W +: RADR_W]),
      .rs_valid  (bus.rs_valid[p]),
      .rd_adr_st (bus.rd_adr_st),
      .wbk_st    (bus.wbk_st),
      .ld_st     (bus.ld_st),
      .stall_st  (bus.stall_st),
      .mask_near (state == LDWAIT),
      .sel       (sel_nxt[p*NFS +: NFS]),
      .nohit     (nohit_nxt[p]),
      .haz       (haz[p]),
      .kmin      (kmin_p[p])
    );
  end

  always_comb begin
    any_haz  = |haz;
    kmin_all = CW'(NFS - 1);
    for (int unsigned p = 0; p < NRP; p++) begin
      if (haz[p] && kmin_p[p] < kmin_all) kmin_all = kmin_p[p];
    end
    need    = CW'(LD_LAT - 1) - kmin_all;
    cnt_dec = (cnt == '0) ? '0 : cnt - 1'b1;
    bus.stall_ld = any_haz | ((state == LDWAIT) && (cnt != '0)) | (bus.stall_fin2 & bus.stall_ld_ex);
  end

  assign bus.ld_busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.fwd_sel_ex  <= '0;
      bus.nohit_ex    <= '0;
      bus.stall_ld_ex <= 1'b0;
      state           <= IDLE;
      cnt             <= '0;
    end else if (bus.rst_pipe) begin
      bus.fwd_sel_ex  <= '0;
      bus.nohit_ex    <= '0;
      bus.stall_ld_ex <= 1'b0;
      state           <= IDLE;
      cnt             <= '0;
    end else begin
      bus.fwd_sel_ex  <= sel_nxt;
      bus.nohit_ex    <= nohit_nxt;
      bus.stall_ld_ex <= bus.stall_ld;
      case (state)
        IDLE: begin
          if (any_haz) begin
            state <= LDWAIT;
            cnt   <= need;
          end
        end
        LDWAIT: begin
          // A fresh hazard keeps the longer of the remaining and newly required wait.
          if (any_haz) begin
            cnt <= (need > cnt_dec) ? need : cnt_dec;
          end else if (cnt == '0) begin
            state <= IDLE;
          end else begin
            cnt <= cnt_dec;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FWD_STAT_EN
  logic [31:0] fwd0_inc;

  always_comb begin
    fwd0_inc = '0;
    for (int unsigned p = 0; p < NRP; p++) begin
      fwd0_inc = fwd0_inc + 32'(sel_nxt[p*NFS]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.stat_ldstall_cnt <= '0;
      bus.stat_fwd0_cnt    <= '0;
    end else if (bus.rst_pipe) begin
      bus.stat_ldstall_cnt <= '0;
      bus.stat_fwd0_cnt    <= '0;
    end else begin
      if (bus.stall_ld && bus.stat_ldstall_cnt != '1)
        bus.stat_ldstall_cnt <= bus.stat_ldstall_cnt + 32'd1;
      bus.stat_fwd0_cnt <= bus.stat_fwd0_cnt + fwd0_inc;
    end
  end
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Two configurations (NFS=3/LD_LAT=1 and NFS=4/LD_LAT=2) driven by shared directed vectors.
module tb_fwd_hazard_unit;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [4:0] rs0, rs1;
  logic [1:0] rsv;
  logic [4:0] rd [4];
  logic [3:0] wbk, ld, stl;
  logic       fin2, rp;

  int n_tests = 0;
  int n_fail  = 0;

  fwd_hazard_unit_if #(.NRP(2), .NFS(3), .RADR_W(5)) ifa ();
  fwd_hazard_unit_if #(.NRP(2), .NFS(4), .RADR_W(5)) ifb ();

  assign ifa.rs_id      = {rs1, rs0};
  assign ifa.rs_valid   = rsv;
  assign ifa.rd_adr_st  = {rd[2], rd[1], rd[0]};
  assign ifa.wbk_st     = wbk[2:0];
  assign ifa.ld_st      = ld[2:0];
  assign ifa.stall_st   = stl[2:0];
  assign ifa.stall_fin2 = fin2;
  assign ifa.rst_pipe   = rp;

  assign ifb.rs_id      = {rs1, rs0};
  assign ifb.rs_valid   = rsv;
  assign ifb.rd_adr_st  = {rd[3], rd[2], rd[1], rd[0]};
  assign ifb.wbk_st     = wbk;
  assign ifb.ld_st      = ld;
  assign ifb.stall_st   = stl;
  assign ifb.stall_fin2 = fin2;
  assign ifb.rst_pipe   = rp;

  fwd_hazard_unit #(.NRP(2), .NFS(3), .RADR_W(5), .LD_LAT(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa));
  fwd_hazard_unit #(.NRP(2), .NFS(4), .RADR_W(5), .LD_LAT(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb));

  typedef struct {
    logic [3:0] sel0, sel1;
    logic [1:0] nohit;
    bit         haz;
    int         kmin;
  } mres_t;

  typedef struct {
    bit         busy;
    int         cnt;
    logic [3:0] sel0, sel1;
    logic [1:0] nohit;
    bit         sldex;
  } mst_t;

  mst_t ma, mb;

  // Reference rules: raw hit, near-stage loads stall, otherwise nearest unmasked hit forwards.
  function automatic mres_t eval(int nfs, int ldl, bit busy);
    mres_t r;
    logic [4:0] src;
    bit hit, found;
    r.sel0 = '0; r.sel1 = '0; r.nohit = 2'b11; r.haz = 0; r.kmin = nfs;
    for (int p = 0; p < 2; p++) begin
      found = 0;
      src = (p == 0) ? rs0 : rs1;
      for (int k = 0; k < nfs; k++) begin
        hit = (rd[k] != 0) && (src == rd[k]) && rsv[p] && wbk[k] && !stl[k];
        if (hit && ld[k] && k < ldl) begin
          r.haz = 1;
          if (k < r.kmin) r.kmin = k;
        end else if (hit && !found && !(busy && k < ldl)) begin
          found = 1;
          if (p == 0) r.sel0[k] = 1'b1; else r.sel1[k] = 1'b1;
          r.nohit[p] = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic bit stall_now(mst_t s, int nfs, int ldl);
    mres_t r;
    r = eval(nfs, ldl, s.busy);
    return r.haz || (s.busy && s.cnt != 0) || (fin2 && s.sldex);
  endfunction

  function automatic mst_t nxt(mst_t s, int nfs, int ldl);
    mst_t  n;
    mres_t r;
    int    need, dec;
    n = '{default: 0};
    if (rp) return n;
    r = eval(nfs, ldl, s.busy);
    n.sel0 = r.sel0; n.sel1 = r.sel1; n.nohit = r.nohit;
    n.sldex = stall_now(s, nfs, ldl);
    need = ldl - 1 - r.kmin;
    dec  = (s.cnt > 0) ? s.cnt - 1 : 0;
    if (!s.busy) begin
      n.busy = r.haz;
      n.cnt  = r.haz ? need : 0;
    end else if (r.haz) begin
      n.busy = 1;
      n.cnt  = (need > dec) ? need : dec;
    end else begin
      n.busy = (s.cnt != 0);
      n.cnt  = dec;
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ma <= '{default: 0};
      mb <= '{default: 0};
    end else begin
      ma <= nxt(ma, 3, 1);
      mb <= nxt(mb, 4, 2);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("a_sel",   32'(ifa.fwd_sel_ex),  32'({ma.sel1[2:0], ma.sel0[2:0]}));
      chk("a_nohit", 32'(ifa.nohit_ex),    32'(ma.nohit));
      chk("a_sld",   32'(ifa.stall_ld),    32'(stall_now(ma, 3, 1)));
      chk("a_sldex", 32'(ifa.stall_ld_ex), 32'(ma.sldex));
      chk("a_busy",  32'(ifa.ld_busy),     32'(ma.busy));
      chk("b_sel",   32'(ifb.fwd_sel_ex),  32'({mb.sel1, mb.sel0}));
      chk("b_nohit", 32'(ifb.nohit_ex),    32'(mb.nohit));
      chk("b_sld",   32'(ifb.stall_ld),    32'(stall_now(mb, 4, 2)));
      chk("b_sldex", 32'(ifb.stall_ld_ex), 32'(mb.sldex));
      chk("b_busy",  32'(ifb.ld_busy),     32'(mb.busy));
    end
  end

  task automatic clear();
    rs0 = '0; rs1 = '0; rsv = '0; wbk = '0; ld = '0; stl = '0; fin2 = 0; rp = 0;
    for (int i = 0; i < 4; i++) rd[i] = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    clear();
    repeat (4) tick();
  endtask

  initial begin
    clear();
    rst_n = 1'b0;
    #12;
    chk("rst_sel",   32'(ifa.fwd_sel_ex), 0);
    chk("rst_nohit", 32'(ifb.nohit_ex), 0);
    chk("rst_sldex", 32'(ifa.stall_ld_ex), 0);
    chk("rst_busy",  32'(ifb.ld_busy), 0);
    rst_n = 1'b1;
    tick();

    // add x5 in EX, rs1 = x5
    rd[0] = 5; wbk = 4'b0001; rs0 = 5; rsv = 2'b01;
    tick();
    chk("fwd_ex_sel",   32'(ifa.fwd_sel_ex[2:0]), 32'b001);
    chk("fwd_ex_nohit", 32'(ifa.nohit_ex[0]), 0);

    // x5 in EX and WB: nearest wins
    rd[2] = 5; wbk = 4'b0101;
    tick();
    chk("nearest", 32'(ifa.fwd_sel_ex), 32'b000_001);
    // x0 never hits
    clear(); rd[0] = 0; wbk = 4'b0001; rs0 = 0; rsv = 2'b01;
    tick();
    chk("x0_nohit", 32'(ifa.nohit_ex[0]), 1);
    settle();

    // lw x7 in EX, rs2 = x7, LD_LAT=1
    rd[0] = 7; wbk = 4'b0001; ld = 4'b0001; rs1 = 7; rsv = 2'b10;
    #1 chk("ld1_stall", 32'(ifa.stall_ld), 1);
    tick();
    rd[0] = 0; rd[1] = 7; wbk = 4'b0010; ld = 4'b0010;
    #1 chk("ld1_sldex", 32'(ifa.stall_ld_ex), 1);
    chk("ld1_free", 32'(ifa.stall_ld), 0);
    tick();
    chk("ld1_fwd", 32'(ifa.fwd_sel_ex[5:3]), 32'b010);
    settle();

    // lw x9 in EX, LD_LAT=2, NFS=4
    rd[0] = 9; wbk = 4'b0001; ld = 4'b0001; rs0 = 9; rsv = 2'b01;
    #1 chk("ld2_stall0", 32'(ifb.stall_ld), 1);
    tick();
    chk("ld2_busy0", 32'(ifb.ld_busy), 1);
    rd[0] = 0; rd[1] = 9; wbk = 4'b0010; ld = 4'b0010;
    #1 chk("ld2_stall1", 32'(ifb.stall_ld), 1);
    tick();
    chk("ld2_busy1", 32'(ifb.ld_busy), 1);
    rd[1] = 0; rd[2] = 9; wbk = 4'b0100; ld = 4'b0100;
    #1 chk("ld2_free", 32'(ifb.stall_ld), 0);
    tick();
    chk("ld2_fwd",  32'(ifb.fwd_sel_ex[3:0]), 32'b0100);
    chk("ld2_idle", 32'(ifb.ld_busy), 0);
    settle();

    // loads hitting both ports at stages 0 and 1: one 2-cycle stall
    rs0 = 11; rs1 = 12; rsv = 2'b11;
    rd[0] = 11; rd[1] = 12; wbk = 4'b0011; ld = 4'b0011;
    #1 chk("dual_stall0", 32'(ifb.stall_ld), 1);
    tick();
    rd[0] = 0; rd[1] = 11; rd[2] = 12; wbk = 4'b0110; ld = 4'b0110;
    #1 chk("dual_stall1", 32'(ifb.stall_ld), 1);
    tick();
    rd[1] = 0; rd[2] = 11; rd[3] = 12; wbk = 4'b1100; ld = 4'b1100;
    #1 chk("dual_free", 32'(ifb.stall_ld), 0);
    tick();
    chk("dual_fwd", 32'(ifb.fwd_sel_ex), 32'b1000_0100);
    settle();

    // flush in the middle of LDWAIT
    rs0 = 11; rsv = 2'b01; rd[0] = 11; wbk = 4'b0001; ld = 4'b0001;
    tick();
    rp = 1;
    #1 chk("rp_comb_stall", 32'(ifb.stall_ld), 1);
    tick();
    chk("rp_busy",  32'(ifb.ld_busy), 0);
    chk("rp_sel",   32'(ifb.fwd_sel_ex), 0);
    chk("rp_nohit", 32'(ifb.nohit_ex), 0);
    chk("rp_sldex", 32'(ifb.stall_ld_ex), 0);
    settle();

    // stall_fin2 stretches the load stall by one cycle
    rd[0] = 7; wbk = 4'b0001; ld = 4'b0001; rs0 = 7; rsv = 2'b01;
    tick();
    clear(); fin2 = 1;
    #1 chk("fin2_ext", 32'(ifa.stall_ld), 1);
    tick();
    fin2 = 0;
    #1 chk("fin2_end", 32'(ifa.stall_ld), 0);
    settle();

    // stalled stage 0 must not forward
    rd[0] = 5; rd[1] = 5; wbk = 4'b0011; stl = 4'b0001; rs0 = 5; rsv = 2'b01;
    tick();
    chk("stl_skip", 32'(ifa.fwd_sel_ex[2:0]), 32'b010);
    stl = 4'b1111;
    tick();
    chk("all_stl_nohit", 32'(ifa.nohit_ex[0]), 1);
    settle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
